counter_sched: RTL and testbench

- Round-robin scheduler that shares one 4-bit up-counter between NREQ requesters.
- Each requester asks for a counting run to its own target value. The scheduler grants the counter to one requester, clears it, and steps it once per cycle until the target is reached, then pulses that requester's done.
- Sits between the requester logic and the counter datapath; the counter is instantiated inside as a sub-module.

---
 rtl/counter_sched_pkg.sv | 21 ++
 rtl/count4_dp.sv | 35 +++
 rtl/counter_sched.sv | 129 ++++++++++++
 tb/tb_counter_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | counter_sched_pkg : shared state encoding and default sizes for the        |
// |                     round-robin counter scheduler                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int c_nreq  = 2;
  localparam int c_width = 4;

endpackage

`default_nettype wire

// File: rtl/count4_dp.sv
// +----------------------------------------------------------------------------+
// | count4_dp : WIDTH-bit up-counter with synchronous clear and enable         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module count4_dp
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = c_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/counter_sched.sv
// +----------------------------------------------------------------------------+
// | counter_sched : round-robin scheduler sharing one up-counter among NREQ    |
// |                 requesters. Optional COUNTER_SCHED_ABORT_EN lets an owner  |
// |                 abandon its run by dropping req.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = c_nreq,
  parameter int WIDTH = c_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] target,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count_out,
  output logic                  busy
);

  localparam int              c_pw  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] c_one = NREQ'(1);

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic [WIDTH-1:0]  r_tgt;
  logic [c_pw-1:0]   r_ptr;
  logic [c_pw-1:0]   r_own;

  logic              w_found;
  logic [c_pw-1:0]   w_win;
  logic [c_pw-1:0]   w_cand;
  logic [c_pw-1:0]   w_next_ptr;
  logic              w_clr;
  logic              w_en;
  logic              w_abort;
  logic [WIDTH-1:0]  w_count;

  // First requester at or after the pointer, wrapping round
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = c_pw'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_next_ptr = c_pw'((int'(w_win) + 1) % NREQ);

`ifdef COUNTER_SCHED_ABORT_EN
  assign w_abort = (r_state == COUNT) && !req[r_own];
`else
  assign w_abort = 1'b0;
`endif

  assign w_clr = (r_state == IDLE) && w_found;
  assign w_en  = (r_state == COUNT) && (w_count != r_tgt) && !w_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_tgt   <= '0;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_grant <= c_one << w_win;
            r_tgt   <= target[int'(w_win)*WIDTH +: WIDTH];
            r_own   <= w_win;
            r_ptr   <= w_next_ptr;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (w_abort) begin
            r_grant <= '0;
            r_state <= IDLE;
          end else if (w_count == r_tgt) begin
            r_grant <= '0;
            r_done  <= c_one << r_own;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_grant <= '0;
          r_done  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  count4_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_en),
    .count (w_count)
  );

  assign grant     = r_grant;
  assign done      = r_done;
  assign count_out = w_count;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_counter_sched.sv
// +----------------------------------------------------------------------------+
// | tb_counter_sched : directed scenarios plus randomized traffic against a    |
// |                    run-timeline reference model                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_counter_sched;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;
  localparam int TW    = NREQ * WIDTH;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic [NREQ-1:0]  req    = '0;
  logic [TW-1:0]    target = '0;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic [WIDTH-1:0] count_out;
  logic             busy;

  int checks = 0;
  int errors = 0;

  counter_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .target    (target),
    .grant     (grant),
    .done      (done),
    .count_out (count_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; req = 2'b11; target = 8'h21;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || count_out !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b done=%b count=%0d busy=%b expected 00 00 0 0",
               grant, done, count_out, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || count_out !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b count=%0d busy=%b expected 01 0 1",
               grant, count_out, busy);
    end
    rst = 1'b0; req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    target = 8'h03; req = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || done !== 2'b00 || count_out !== WIDTH'(k)) begin
        errors++;
        $display("FAIL single_run: grant=%b done=%b count=%0d expected 01 00 %0d",
                 grant, done, count_out, k);
      end
      if (k == 1) target = 8'h09;
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || done !== 2'b01 || count_out !== 4'd3) begin
      errors++;
      $display("FAIL single_done: grant=%b done=%b count=%0d expected 00 01 3",
               grant, done, count_out);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || busy !== 1'b0 || count_out !== 4'd3) begin
      errors++;
      $display("FAIL single_idle: done=%b busy=%b count=%0d expected 00 0 3",
               done, busy, count_out);
    end
  endtask

  task automatic test_target_zero();
    target = 8'h05; req = 2'b10;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || count_out !== 4'd0 || done !== 2'b00) begin
      errors++;
      $display("FAIL zero_grant: grant=%b count=%0d done=%b expected 10 0 00",
               grant, count_out, done);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || done !== 2'b10 || count_out !== 4'd0) begin
      errors++;
      $display("FAIL zero_done: grant=%b done=%b count=%0d expected 00 10 0",
               grant, done, count_out);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int own[3] = '{0, 1, 0};
    int tg[3]  = '{1, 2, 1};
    logic [NREQ-1:0] eg;
    target = {4'd2, 4'd1}; req = 2'b11;
    for (int r = 0; r < 3; r++) begin
      eg = NREQ'(1) << own[r];
      for (int k = 0; k <= tg[r]; k++) begin
        @(negedge clk);
        checks++;
        if (grant !== eg || done !== 2'b00 || count_out !== WIDTH'(k)) begin
          errors++;
          $display("FAIL arb_grant run%0d: grant=%b done=%b count=%0d expected %b 00 %0d",
                   r, grant, done, count_out, eg, k);
        end
      end
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || done !== eg) begin
        errors++;
        $display("FAIL arb_done run%0d: grant=%b done=%b expected 00 %b", r, grant, done, eg);
      end
      if (r == 2) req = 2'b00;
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL arb_gap run%0d: grant=%b done=%b busy=%b expected 00 00 0",
                 r, grant, done, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    target = 8'h0F; req = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || count_out !== WIDTH'(k)) begin
        errors++;
        $display("FAIL midrst_run: grant=%b count=%0d expected 01 %0d", grant, count_out, k);
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || count_out !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: grant=%b done=%b count=%0d busy=%b expected 00 00 0 0",
               grant, done, count_out, busy);
    end
    req = 2'b11;
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || grant !== 2'b00) begin
      errors++;
      $display("FAIL midrst_hold: grant=%b done=%b expected 00 00", grant, done);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL midrst_ptr: grant=%b expected 01", grant);
    end
    rst = 1'b0; req = 2'b10;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL midrst_req1: grant=%b expected 10", grant);
    end
    rst = 1'b0; req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_abort();
    target = 8'h0A; req = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || count_out !== WIDTH'(k)) begin
        errors++;
        $display("FAIL abort_run: grant=%b count=%0d expected 01 %0d", grant, count_out, k);
      end
    end
    req = 2'b00;
`ifdef COUNTER_SCHED_ABORT_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || done !== 2'b00 || count_out !== 4'd4 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_stop: grant=%b done=%b count=%0d busy=%b expected 00 00 4 0",
                 grant, done, count_out, busy);
      end
    end
`else
    for (int k = 5; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || count_out !== WIDTH'(k)) begin
        errors++;
        $display("FAIL noabort_run: grant=%b count=%0d expected 01 %0d", grant, count_out, k);
      end
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || done !== 2'b01 || count_out !== 4'd10) begin
      errors++;
      $display("FAIL noabort_done: grant=%b done=%b count=%0d expected 00 01 10",
               grant, done, count_out);
    end
    @(negedge clk);
`endif
  endtask

  // Reference: each run is a timeline from its grant cycle s with target t:
  // grant during s..s+t, done at s+t+1, idle from s+t+2 where req is sampled.
  task automatic test_random();
    int m_owner = -1;
    int m_start = 0;
    int m_tgt   = 0;
    int m_ptr   = 0;
    int ph;
    logic [NREQ-1:0]  eg, ed;
    logic [WIDTH-1:0] ec;
    logic             eb;
    rst = 1'b0; req = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 1500; c++) begin
      ph = (m_owner < 0) ? 1000 : (c - 1 - m_start);
      if (ph >= m_tgt + 2 && req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int w;
          w = (m_ptr + k) % NREQ;
          if (req[w]) begin
            m_owner = w;
            m_start = c;
            m_tgt   = int'(target[w*WIDTH +: WIDTH]);
            m_ptr   = (w + 1) % NREQ;
            break;
          end
        end
      end
      @(negedge clk);
      ph = (m_owner < 0) ? 1000 : (c - m_start);
      if (ph <= m_tgt) begin
        eg = NREQ'(1) << m_owner; ed = '0; ec = WIDTH'(ph); eb = 1'b1;
      end else if (ph == m_tgt + 1) begin
        eg = '0; ed = NREQ'(1) << m_owner; ec = WIDTH'(m_tgt); eb = 1'b1;
      end else begin
        eg = '0; ed = '0; ec = (m_owner < 0) ? '0 : WIDTH'(m_tgt); eb = 1'b0;
      end
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL rand_grant cyc%0d: got %b expected %b", c, grant, eg);
      end
      checks++;
      if (done !== ed) begin
        errors++;
        $display("FAIL rand_done cyc%0d: got %b expected %b", c, done, ed);
      end
      checks++;
      if (count_out !== ec) begin
        errors++;
        $display("FAIL rand_count cyc%0d: got %0d expected %0d", c, count_out, ec);
      end
      checks++;
      if (busy !== eb) begin
        errors++;
        $display("FAIL rand_busy cyc%0d: got %b expected %b", c, busy, eb);
      end
      if (ed != '0) req[m_owner] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !ed[i] && $urandom_range(3) == 0) req[i] = 1'b1;
      end
      target = TW'($urandom);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_target_zero();
    test_arbitration();
    test_mid_reset();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
